jelly3_axi4l_register_file: RTL

Parametrised AXI4-Lite register file that generalises the plain RW register block.
- Per-register access mode: RW, RO status, W1C sticky, self-clearing PULSE.
- AW and W channels accepted independently.
- Out-of-range accesses answered with SLVERR.
- Per-register write strobes.
- Sits between the AXI4-Lite interconnect and core control/status logic.

---
 rtl/jelly3_axi4l_register_file.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/jelly3_axi4l_register_file.sv
// AXI4-Lite register file with per-register RW / RO / W1C / PULSE modes and independent AW/W capture.
// Optional value shadowing is enabled by defining JELLY3_AXI4L_REGISTER_FILE_SHADOW_EN.
module jelly3_axi4l_register_file #(
    parameter int                         NUM       = 8,
    parameter int                         BITS      = 32,
    parameter int                         ADDR_BITS = 12,
    parameter int                         DATA_BITS = 32,
    parameter logic [NUM-1:0][1:0]        MODE      = '0,
    parameter logic [NUM-1:0][BITS-1:0]   INIT      = '0
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef JELLY3_AXI4L_REGISTER_FILE_SHADOW_EN
    input  logic                      shadow_update,
`endif
    input  logic [ADDR_BITS-1:0]      s_axi4l_awaddr,
    input  logic                      s_axi4l_awvalid,
    output logic                      s_axi4l_awready,
    input  logic [DATA_BITS-1:0]      s_axi4l_wdata,
    input  logic [DATA_BITS/8-1:0]    s_axi4l_wstrb,
    input  logic                      s_axi4l_wvalid,
    output logic                      s_axi4l_wready,
    output logic [1:0]                s_axi4l_bresp,
    output logic                      s_axi4l_bvalid,
    input  logic                      s_axi4l_bready,
    input  logic [ADDR_BITS-1:0]      s_axi4l_araddr,
    input  logic                      s_axi4l_arvalid,
    output logic                      s_axi4l_arready,
    output logic [DATA_BITS-1:0]      s_axi4l_rdata,
    output logic [1:0]                s_axi4l_rresp,
    output logic                      s_axi4l_rvalid,
    input  logic                      s_axi4l_rready,
    input  logic [NUM*BITS-1:0]       status_in,
    output logic [NUM*BITS-1:0]       value,
    output logic [NUM-1:0]            wr_pulse
);

    localparam int                LSB      = $clog2(DATA_BITS / 8);
    localparam int                IDX_BITS = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IDX_BITS:0] NUM_L    = (IDX_BITS + 1)'(NUM);
    localparam logic [1:0]        MODE_RW  = 2'd0;
    localparam logic [1:0]        MODE_RO  = 2'd1;
    localparam logic [1:0]        MODE_W1C = 2'd2;
    localparam logic [1:0]        MODE_PLS = 2'd3;

    if (BITS > DATA_BITS) begin : g_bits_check
        $error("BITS must not exceed DATA_BITS");
    end

    logic                       aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [IDX_BITS-1:0]        aw_idx_q, aw_idx_d;
    logic [BITS-1:0]            w_data_q, w_data_d, w_mask_q, w_mask_d, wmask_in_s;
    logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_BITS-1:0]       rdata_q, rdata_d;
    logic [NUM-1:0]             wr_pulse_q, wr_pulse_d, sel_s;
    logic [NUM-1:0][BITS-1:0]   reg_q, reg_d;
    logic [IDX_BITS-1:0]        ar_idx_s;
    logic [BITS-1:0]            rd_val_s;
    logic                       aw_hit_s, ar_hit_s, commit_s, aw_fire_s, w_fire_s, ar_fire_s;
    logic                       unused_s;

    assign unused_s        = ^{s_axi4l_awaddr, s_axi4l_araddr, s_axi4l_wdata, s_axi4l_wstrb};
    assign aw_hit_s        = {1'b0, aw_idx_q} < NUM_L;
    assign ar_idx_s        = s_axi4l_araddr[LSB +: IDX_BITS];
    assign ar_hit_s        = {1'b0, ar_idx_s} < NUM_L;
    assign s_axi4l_awready = ~aw_full_q;
    assign s_axi4l_wready  = ~w_full_q;
    assign s_axi4l_arready = ~rvalid_q | s_axi4l_rready;
    assign aw_fire_s       = s_axi4l_awvalid & ~aw_full_q;
    assign w_fire_s        = s_axi4l_wvalid & ~w_full_q;
    assign ar_fire_s       = s_axi4l_arvalid & s_axi4l_arready;
    assign commit_s        = aw_full_q & w_full_q & (~bvalid_q | s_axi4l_bready);
    assign s_axi4l_bvalid  = bvalid_q;
    assign s_axi4l_bresp   = bresp_q;
    assign s_axi4l_rvalid  = rvalid_q;
    assign s_axi4l_rresp   = rresp_q;
    assign s_axi4l_rdata   = rdata_q;
    assign wr_pulse        = wr_pulse_q;

    // Channel holds and response next-state; a fill and a commit never coincide on the same hold
    always_comb begin
        wmask_in_s = '0;
        for (int b = 0; b < BITS; b++) begin
            wmask_in_s[b] = s_axi4l_wstrb[b / 8];
        end
        aw_full_d = aw_fire_s ? 1'b1 : (commit_s ? 1'b0 : aw_full_q);
        w_full_d  = w_fire_s  ? 1'b1 : (commit_s ? 1'b0 : w_full_q);
        aw_idx_d  = aw_fire_s ? s_axi4l_awaddr[LSB +: IDX_BITS] : aw_idx_q;
        w_data_d  = w_fire_s  ? s_axi4l_wdata[BITS-1:0] : w_data_q;
        w_mask_d  = w_fire_s  ? wmask_in_s : w_mask_q;
        bvalid_d  = commit_s  ? 1'b1 : (s_axi4l_bready ? 1'b0 : bvalid_q);
        bresp_d   = commit_s  ? (aw_hit_s ? 2'b00 : 2'b10) : bresp_q;
    end

    // Per-register next value; the W1C set term is OR-ed last so it wins over a clear
    always_comb begin
        reg_d      = reg_q;
        sel_s      = '0;
        wr_pulse_d = '0;
        for (int i = 0; i < NUM; i++) begin
            sel_s[i]      = commit_s & aw_hit_s & (aw_idx_q == IDX_BITS'(i));
            wr_pulse_d[i] = sel_s[i];
            case (MODE[i])
                MODE_RW:  reg_d[i] = sel_s[i] ? ((reg_q[i] & ~w_mask_q) | (w_data_q & w_mask_q)) : reg_q[i];
                MODE_W1C: reg_d[i] = (reg_q[i] & ~(sel_s[i] ? (w_data_q & w_mask_q) : {BITS{1'b0}}))
                                     | status_in[i*BITS +: BITS];
                MODE_PLS: reg_d[i] = sel_s[i] ? (w_data_q & w_mask_q) : {BITS{1'b0}};
                default:  reg_d[i] = {BITS{1'b0}};
            endcase
        end
    end

    // Read source mux; uses current contents so a same-cycle write is not visible
    always_comb begin
        rd_val_s = '0;
        for (int i = 0; i < NUM; i++) begin
            if (ar_idx_s == IDX_BITS'(i)) begin
                case (MODE[i])
                    MODE_RO:  rd_val_s = status_in[i*BITS +: BITS];
                    MODE_PLS: rd_val_s = {BITS{1'b0}};
                    default:  rd_val_s = reg_q[i];
                endcase
            end else begin
                rd_val_s = rd_val_s;
            end
        end
        rvalid_d = ar_fire_s ? 1'b1 : (s_axi4l_rready ? 1'b0 : rvalid_q);
        rdata_d  = ar_fire_s ? (ar_hit_s ? DATA_BITS'(rd_val_s) : {DATA_BITS{1'b0}}) : rdata_q;
        rresp_d  = ar_fire_s ? (ar_hit_s ? 2'b00 : 2'b10) : rresp_q;
    end

    // Handshake and response state
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_mask_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            aw_idx_q  <= aw_idx_d;
            w_data_q  <= w_data_d;
            w_mask_q  <= w_mask_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Register storage; RO and PULSE entries reset to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM; i++) begin
                reg_q[i] <= (MODE[i] == MODE_RW || MODE[i] == MODE_W1C) ? INIT[i] : {BITS{1'b0}};
            end
            wr_pulse_q <= '0;
        end else begin
            reg_q      <= reg_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

`ifdef JELLY3_AXI4L_REGISTER_FILE_SHADOW_EN
    logic [NUM-1:0][BITS-1:0] shadow_q;

    // Shadow copy captures the pre-commit working contents
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= INIT;
        end else if (shadow_update) begin
            shadow_q <= reg_q;
        end else begin
            shadow_q <= shadow_q;
        end
    end
`endif

    // Core-facing view; RO and PULSE always bypass any shadow
    always_comb begin
        value = '0;
        for (int i = 0; i < NUM; i++) begin
            case (MODE[i])
                MODE_RO:  value[i*BITS +: BITS] = status_in[i*BITS +: BITS];
                MODE_PLS: value[i*BITS +: BITS] = reg_q[i];
`ifdef JELLY3_AXI4L_REGISTER_FILE_SHADOW_EN
                default:  value[i*BITS +: BITS] = shadow_q[i];
`else
                default:  value[i*BITS +: BITS] = reg_q[i];
`endif
            endcase
        end
    end

endmodule
